alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Decode/issue stage driving the ALU's command side and consuming its flag side.
//  - Decodes a 32-bit ARM-style instruction into the ALU command code and control bits.
//  - Owns the NZCV status register, written from the ALU flag outputs.
//  - Evaluates the condition field against that register.
//  - Registers the result into the ID/EX boundary, with a one-bubble flag-hazard interlock.
// PARAMETERS
//  (none; widths fixed: instr 32, alu_cmd 4, SR 4)
// PORTS
//  clk        in   1   rising-edge clock (single clock domain)
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   instr holds a valid instruction
//  in_ready   out  1   instr is consumed this cycle (in_valid & in_ready)
//  instr      in   32  [31:28] cond, [27:26] mode, [25] I, [24:21] opcode, [20] S/L
//  stall      in   1   downstream freeze; outputs hold, nothing consumed
//  flush      in   1   branch taken; drop decode-side instruction
//  alu_n/z/c/v in  1 each  ALU flag outputs of the EX-stage op
//  out_valid  out  1   registered: issued op valid in EX
//  alu_cmd    out  4   registered ALU command
//  c_in       out  1   registered carry-in (SR.C at issue)
//  wb_en      out  1   registered register-file write enable
//  mem_rd     out  1   registered LDR
//  mem_wr     out  1   registered STR
//  s_upd      out  1   registered: op updates SR
//  branch     out  1   registered: op is a branch
//  imm        out  1   registered I bit
//  sr         out  4   status register {N,Z,C,V}
// BEHAVIOUR
//  Reset: every registered output and sr = 0. FSM = ISSUE. in_ready = 1 out of reset.
//  Decode, mode 00 data processing:
//   - opcode->alu_cmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011,
//     SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000,
//     CMP 1010->0100, TST 1000->0110.
//   - wb_en = 1 except CMP/TST. s_upd = S, forced 1 for CMP/TST.
//   - Any other opcode -> alu_cmd 0000, wb_en 0.
//  Decode, mode 01 memory: alu_cmd 0010; L=1 -> mem_rd=1, wb_en=1; L=0 -> mem_wr=1.
//  Decode, mode 10 branch: branch=1, alu_cmd 0000. Mode 11 -> out_valid 0 (NOP).
//  Conditions: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z;
//   GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL(1110) 1; 1111 0.
//   Failed condition: instruction consumed, issued as bubble (out_valid=0 next cycle).
//  SR update: edge where out_valid & s_upd & !stall -> sr <= {alu_n,alu_z,alu_c,alu_v}.
//   Honoured even when flush=1 (EX op already committed).
//  FSM:
//   - ISSUE -> WAIT_FLAG when all hold: in_valid, !stall, !flush, out_valid & s_upd,
//     and incoming needs flags (cond!=AL, or ADC/SBC).
//     In this state: in_ready=0, out_valid<=0 next edge.
//   - WAIT_FLAG -> ISSUE unconditionally next edge. SR is current; instruction issues
//     normally (in_ready=1). Total penalty one bubble.
//  Priority per edge: rst > flush > stall > issue.
//   - flush: out_valid<=0, in_ready=1 (instruction dropped), FSM->ISSUE.
//   - stall (no flush): all outputs and FSM hold, in_ready=0.
//  Latency: consumed instruction appears on outputs 1 cycle later (2 with hazard).
//  in_ready is combinational from FSM/stall/flush/hazard; never from instr alone when !in_valid.
//  Reset mid-WAIT_FLAG: returns to ISSUE, pending instruction lost (upstream re-fetches).
// STRUCTURE
//  Shared package alu_pkg: ALU command codes, ARM opcode and cond encodings, mode codes,
//   SR bit indices. To be used by ALU and this block alike.
//  One sub-module: cond_check (combinational cond[3:0] x sr[3:0] -> pass).
//  Decoder, FSM, SR and output register live in this module.
// TESTING
//  1 Reset mid-stream: rst pulse with outputs active -> all outputs and sr = 0 immediately,
//    in_ready=1 after release.
//  2 ADDS (cond AL, opcode 0100, S=1) then ADD cond EQ, ALU z=1 -> one bubble,
//    sr=0100, EQ op issues alu_cmd 0010, out_valid 1 two cycles after first issue.
//  3 ADC with sr.C=1, no hazard -> alu_cmd 0011, c_in=1, back-to-back issue.
//  4 CMP cond NE with sr.Z=1 -> consumed, out_valid=0, wb_en irrelevant, sr unchanged.
//  5 stall held 3 cycles during LDR issue -> outputs frozen (mem_rd=1, alu_cmd 0010),
//    in_ready=0 throughout.
//  6 flush coincident with stall and SR-writing EX op -> out_valid=0 next edge,
//    sr still updated, instruction dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// Encodings shared by the ALU and its issue stage: ALU commands, ARM opcodes,
// condition codes, instruction modes and status-register bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'b0000,
        ALU_MOV = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_ADC = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SBC = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000,
        ALU_MVN = 4'b1001
    } alu_cmd_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_NOP = 2'b11;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

    typedef struct packed {
        logic       vld;
        logic [3:0] alu_cmd;
        logic       wb_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       s_upd;
        logic       branch;
        logic       imm;
    } issue_t;

    // True when the instruction reads NZCV: any real condition, or a carry-consuming op.
    function automatic logic needs_flags(input logic [3:0] cond,
                                         input logic [1:0] mode,
                                         input logic [3:0] opcode);
        logic carry_op;
        carry_op = (mode == MODE_DP) && ((opcode == OP_ADC) || (opcode == OP_SBC));
        return (cond != COND_AL) || carry_op;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_check.sv
// Condition-field evaluation against NZCV.
// Purely combinational, no backpressure.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] sr,
    output logic       pass
);

    logic n, z, c, v;

    assign n = sr[SR_N];
    assign z = sr[SR_Z];
    assign c = sr[SR_C];
    assign v = sr[SR_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode/issue stage: decodes an instruction, checks its condition, owns NZCV.
// Latency 1 cycle (2 on a flag hazard); stall freezes everything, flush overrides stall.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        out_valid,
    output logic [3:0]  alu_cmd,
    output logic        c_in,
    output logic        wb_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        s_upd,
    output logic        branch,
    output logic        imm,
    output logic [3:0]  sr
);

    localparam logic [0:0] ST_ISSUE     = 1'b0;
    localparam logic [0:0] ST_WAIT_FLAG = 1'b1;

    logic [0:0] state;
    issue_t     dec;
    issue_t     out_q;
    logic       c_in_q;
    logic       cond_pass;
    logic       hazard;
    logic       sr_wr;
    logic       issue_vld;

    logic [3:0] f_cond;
    logic [1:0] f_mode;
    logic [3:0] f_opcode;
    logic       f_imm;
    logic       f_sl;
    logic       unused_instr_bits;

    assign f_cond            = instr[31:28];
    assign f_mode            = instr[27:26];
    assign f_imm             = instr[25];
    assign f_opcode          = instr[24:21];
    assign f_sl              = instr[20];
    assign unused_instr_bits = ^instr[19:0];

    cond_check u_cond_check (
        .cond (f_cond),
        .sr   (sr),
        .pass (cond_pass)
    );

    always_comb begin
        dec     = '0;
        dec.imm = f_imm;
        case (f_mode)
            MODE_DP: begin
                dec.vld   = 1'b1;
                dec.wb_en = 1'b1;
                dec.s_upd = f_sl;
                case (f_opcode)
                    OP_MOV: dec.alu_cmd = ALU_MOV;
                    OP_MVN: dec.alu_cmd = ALU_MVN;
                    OP_ADD: dec.alu_cmd = ALU_ADD;
                    OP_ADC: dec.alu_cmd = ALU_ADC;
                    OP_SUB: dec.alu_cmd = ALU_SUB;
                    OP_SBC: dec.alu_cmd = ALU_SBC;
                    OP_AND: dec.alu_cmd = ALU_AND;
                    OP_ORR: dec.alu_cmd = ALU_ORR;
                    OP_EOR: dec.alu_cmd = ALU_EOR;
                    OP_CMP: begin
                        dec.alu_cmd = ALU_SUB;
                        dec.wb_en   = 1'b0;
                        dec.s_upd   = 1'b1;
                    end
                    OP_TST: begin
                        dec.alu_cmd = ALU_AND;
                        dec.wb_en   = 1'b0;
                        dec.s_upd   = 1'b1;
                    end
                    default: begin
                        dec.alu_cmd = ALU_NOP;
                        dec.wb_en   = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                dec.vld     = 1'b1;
                dec.alu_cmd = ALU_ADD;
                dec.mem_rd  = f_sl;
                dec.wb_en   = f_sl;
                dec.mem_wr  = !f_sl;
            end
            MODE_BR: begin
                dec.vld     = 1'b1;
                dec.branch  = 1'b1;
                dec.alu_cmd = ALU_NOP;
            end
            default: dec = '0;
        endcase
    end

    // The EX op is about to write NZCV and the incoming op would read it: hold one cycle.
    assign hazard = (state == ST_ISSUE) & in_valid & !stall & !flush
                  & out_valid & s_upd & needs_flags(f_cond, f_mode, f_opcode);

    assign in_ready  = flush | (!stall & !hazard);
    assign issue_vld = in_valid & dec.vld & cond_pass;

    // A flush releases a stalled EX op, so its flag write still lands.
    assign sr_wr = out_valid & s_upd & (flush | !stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= 4'b0000;
        end else if (sr_wr) begin
            sr <= {alu_n, alu_z, alu_c, alu_v};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_ISSUE;
            out_q  <= '0;
            c_in_q <= 1'b0;
        end else if (flush) begin
            state  <= ST_ISSUE;
            out_q  <= '0;
            c_in_q <= 1'b0;
        end else if (!stall) begin
            if (hazard) begin
                state  <= ST_WAIT_FLAG;
                out_q  <= '0;
                c_in_q <= 1'b0;
            end else begin
                state <= ST_ISSUE;
                if (issue_vld) begin
                    out_q  <= dec;
                    c_in_q <= sr[SR_C];
                end else begin
                    out_q  <= '0;
                    c_in_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_q.vld;
    assign alu_cmd   = out_q.alu_cmd;
    assign c_in      = c_in_q;
    assign wb_en     = out_q.wb_en;
    assign mem_rd    = out_q.mem_rd;
    assign mem_wr    = out_q.mem_wr;
    assign s_upd     = out_q.s_upd;
    assign branch    = out_q.branch;
    assign imm       = out_q.imm;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic against an
// instruction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic        out_valid;
    logic [3:0]  alu_cmd;
    logic        c_in, wb_en, mem_rd, mem_wr, s_upd, branch, imm;
    logic [3:0]  sr;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .stall     (stall),
        .flush     (flush),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .out_valid (out_valid),
        .alu_cmd   (alu_cmd),
        .c_in      (c_in),
        .wb_en     (wb_en),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .s_upd     (s_upd),
        .branch    (branch),
        .imm       (imm),
        .sr        (sr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what is sitting in EX and of the status register.
    logic       m_vld, m_cin, m_wb, m_rd, m_wr, m_s, m_br, m_imm;
    logic [3:0] m_cmd;
    logic [3:0] m_sr;
    int         dp_map [16];
    logic       last_rdy;

    localparam logic [31:0] I_ADDS_AL = 32'hE090_0000;
    localparam logic [31:0] I_ADD_AL  = 32'hE080_0000;
    localparam logic [31:0] I_ADD_EQ  = 32'h0080_0000;
    localparam logic [31:0] I_MOVS_AL = 32'hE1B0_0000;
    localparam logic [31:0] I_ADC_AL  = 32'hE0A0_0000;
    localparam logic [31:0] I_TST_AL  = 32'hE100_0000;
    localparam logic [31:0] I_CMP_NE  = 32'h1140_0000;
    localparam logic [31:0] I_LDR_AL  = 32'hE410_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even codes test a predicate, the following odd code is its negation; 1111 never passes.
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] == 1'b0;
        endcase
        return base ^ c[0];
    endfunction

    function automatic bit m_needs(input logic [31:0] ins);
        logic [3:0] op;
        op = ins[24:21];
        return (ins[31:28] != 4'hE) || (ins[27:26] == 2'b00 && (op == 4'h5 || op == 4'h6));
    endfunction

    task automatic model_reset();
        m_vld = 0; m_cin = 0; m_wb = 0; m_rd = 0; m_wr = 0;
        m_s = 0; m_br = 0; m_imm = 0; m_cmd = 4'h0; m_sr = 4'h0;
    endtask

    task automatic compare_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
        check("sr", {28'd0, sr}, {28'd0, m_sr});
        if (m_vld)
            check("issue_fields",
                  {20'd0, alu_cmd, c_in, wb_en, mem_rd, mem_wr, s_upd, branch, imm},
                  {20'd0, m_cmd, m_cin, m_wb, m_rd, m_wr, m_s, m_br, m_imm});
    endtask

    // One clock: drive at negedge, check in_ready, advance the model, check outputs at next negedge.
    task automatic step(input bit v, input logic [31:0] ins, input bit st, input bit fl,
                        input logic [3:0] flags);
        bit         hz, exp_rdy, cmp_tst;
        logic [3:0] nsr, op;
        int         code;
        in_valid = v; instr = ins; stall = st; flush = fl;
        {alu_n, alu_z, alu_c, alu_v} = flags;
        #1;
        hz      = v && !st && !fl && m_vld && m_s && m_needs(ins);
        exp_rdy = fl || (!st && !hz);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        last_rdy = in_ready;

        nsr = (m_vld && m_s && (fl || !st)) ? flags : m_sr;
        if (fl || (!st && (hz || !v))) begin
            m_vld = 0;
        end else if (!st) begin
            op   = ins[24:21];
            m_cmd = 4'h0; m_wb = 0; m_rd = 0; m_wr = 0; m_s = 0; m_br = 0;
            m_imm = ins[25];
            m_cin = m_sr[1];
            m_vld = m_cond(ins[31:28], m_sr);
            case (ins[27:26])
                2'b00: begin
                    cmp_tst = (op == 4'hA) || (op == 4'h8);
                    code    = dp_map[op];
                    m_cmd   = (code < 0) ? 4'h0 : 4'(code);
                    m_wb    = (code >= 0) && !cmp_tst;
                    m_s     = ins[20] || cmp_tst;
                end
                2'b01: begin
                    m_cmd = 4'h2; m_rd = ins[20]; m_wr = !ins[20]; m_wb = ins[20];
                end
                2'b10: m_br = 1;
                default: m_vld = 0;
            endcase
            if (!m_vld) m_s = 0;
        end
        m_sr = nsr;

        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 2) != 0) r[31:28] = 4'hE;
        if ($urandom_range(0, 3) != 0) r[27:26] = 2'b00;
        if ($urandom_range(0, 3) == 0) r[24:21] = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'h6;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (dp_map[i]) dp_map[i] = -1;
        dp_map[13] = 1; dp_map[15] = 9; dp_map[4] = 2;  dp_map[5] = 3;
        dp_map[2]  = 4; dp_map[6]  = 5; dp_map[0] = 6;  dp_map[12] = 7;
        dp_map[1]  = 8; dp_map[10] = 4; dp_map[8] = 6;

        rst = 1; in_valid = 0; instr = 0; stall = 0; flush = 0;
        {alu_n, alu_z, alu_c, alu_v} = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_sr", {28'd0, sr}, 32'd0);
        check("reset_fields", {20'd0, alu_cmd, c_in, wb_en, mem_rd, mem_wr, s_upd, branch, imm}, 32'd0);
        rst = 0;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Flag hazard: ADDS then ADDEQ with the ALU reporting Z.
        step(1, I_ADDS_AL, 0, 0, 4'h0);
        step(1, I_ADD_EQ, 0, 0, 4'b0100);
        check("hazard_in_ready", {31'd0, last_rdy}, 32'd0);
        check("hazard_bubble", {31'd0, out_valid}, 32'd0);
        check("hazard_sr", {28'd0, sr}, 32'h4);
        step(1, I_ADD_EQ, 0, 0, 4'h0);
        check("hazard_retry_ready", {31'd0, last_rdy}, 32'd1);
        check("hazard_issue_valid", {31'd0, out_valid}, 32'd1);
        check("hazard_issue_cmd", {28'd0, alu_cmd}, 32'h2);

        // ADC picks up carry, back-to-back with no hazard.
        step(1, I_MOVS_AL, 0, 0, 4'h0);
        step(0, 32'h0, 0, 0, 4'b0010);
        step(1, I_ADC_AL, 0, 0, 4'h0);
        check("adc_cmd", {28'd0, alu_cmd}, 32'h3);
        check("adc_c_in", {31'd0, c_in}, 32'd1);
        step(1, I_ADC_AL, 0, 0, 4'h0);
        check("adc_b2b_ready", {31'd0, last_rdy}, 32'd1);
        check("adc_b2b_valid", {31'd0, out_valid}, 32'd1);

        // Failed condition: CMPNE with Z set is consumed as a bubble.
        step(1, I_TST_AL, 0, 0, 4'h0);
        step(0, 32'h0, 0, 0, 4'b0100);
        step(1, I_CMP_NE, 0, 0, 4'h0);
        check("condfail_ready", {31'd0, last_rdy}, 32'd1);
        check("condfail_valid", {31'd0, out_valid}, 32'd0);
        step(0, 32'h0, 0, 0, 4'hF);
        check("condfail_sr", {28'd0, sr}, 32'h4);

        // Stall holds an LDR in EX.
        step(1, I_LDR_AL, 0, 0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            step(1, rand_instr(), 1, 0, 4'($urandom));
            check("stall_ready", {31'd0, last_rdy}, 32'd0);
            check("stall_hold", {25'd0, out_valid, mem_rd, alu_cmd, wb_en}, {25'd0, 7'b1100101});
        end
        step(0, 32'h0, 0, 0, 4'h0);

        // Flush with stall while an SR-writing op sits in EX.
        step(1, I_ADDS_AL, 0, 0, 4'h0);
        step(1, I_ADD_AL, 1, 1, 4'b1011);
        check("flush_ready", {31'd0, last_rdy}, 32'd1);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_sr", {28'd0, sr}, 32'hB);
        step(0, 32'h0, 0, 0, 4'h0);

        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) < 2,
                 $urandom_range(0, 19) == 0, 4'($urandom));

        // Reset while outputs are active.
        step(0, 32'h0, 1'b0, 1'b0, 4'h0);
        step(1, I_MOVS_AL, 0, 0, 4'h0);
        step(1, I_MOVS_AL, 0, 0, 4'hF);
        rst = 1; in_valid = 0; stall = 0; flush = 0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sr", {28'd0, sr}, 32'd0);
        check("midrst_fields", {20'd0, alu_cmd, c_in, wb_en, mem_rd, mem_wr, s_upd, branch, imm}, 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        step(1, I_ADD_AL, 0, 0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
